// File: rtl/im_prog_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, stream framing constants, busy decode.
package im_prog_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_HDR  = 3'd1;
  localparam state_t ST_LOAD = 3'd2;
  localparam state_t ST_CSUM = 3'd3;
  localparam state_t ST_DONE = 3'd4;
  localparam state_t ST_ERR  = 3'd5;

  // Length header is a 16-bit word count, MSB first.
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // States in which the loader is consuming the byte stream.
  function automatic logic is_busy(input state_t s);
    return (s == ST_HDR) || (s == ST_LOAD) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/im_word_packer.sv
// Packs a byte stream big-endian into 32-bit words.
// Latency: word_vld/word_dat one cycle after the 4th byte of a word.
// Backpressure: none; caller gates byte_vld, one byte per cycle sustained.
//
// Ports: CLK, RST_N (async active-low); clr drops any partial word;
//        byte_vld/byte_dat in; word_done (comb, 4th byte now);
//        word_vld (one-cycle pulse) / word_dat (held until next word).
module im_word_packer
  import im_prog_loader_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_done,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  byte_cnt;
  logic [23:0] sreg;

  assign word_done = byte_vld && (byte_cnt == LAST_BYTE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      byte_cnt <= '0;
      sreg     <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= word_done;
      if (clr) begin
        byte_cnt <= '0;
      end else if (byte_vld) begin
        byte_cnt <= byte_cnt + 2'd1;
        sreg     <= {sreg[15:0], byte_dat};
      end
      // First byte of the word has shifted up to bits 31:24 by now.
      if (word_done) begin
        word_dat <= {sreg, byte_dat};
      end
    end
  end

endmodule

// File: rtl/im_prog_loader.sv
// Loads a length-prefixed byte stream into instruction memory, CPU held in reset.
// Latency: WE one cycle after the 4th byte of each word; no stall between words.
// Backpressure: registered IN_READY, high only while consuming header/payload/checksum.
//
// Ports: CLK, RST_N (async active-low); START; IN_DATA/IN_VALID/IN_READY stream;
//        WE/W_Addr/W_Ins IM write port; CPU_RST, BUSY, DONE, ERR, WORD_CNT status.
// Build option: define IM_LOADER_CHECKSUM_EN to require a trailing 8-bit
//        modulo-256 sum of the payload bytes before releasing the CPU.
module im_prog_loader
  import im_prog_loader_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 1024
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [7:0]        IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              WE,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [31:0]       W_Ins,
  output logic              CPU_RST,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [15:0]       WORD_CNT
);

  localparam logic HDR_LAST = 1'(HDR_BYTES - 1);

`ifdef IM_LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_PAYLOAD = ST_CSUM;
`else
  localparam state_t ST_AFTER_PAYLOAD = ST_DONE;
`endif

  state_t      state, state_nxt;
  logic        accept;
  logic        start_ok;
  logic        hdr_idx;
  logic [7:0]  hdr_hi;
  logic [15:0] hdr_n;
  logic [15:0] n_words;
  logic        pk_byte_vld;
  logic        pk_word_done;
  logic        last_word;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign accept      = IN_VALID && IN_READY;
  assign start_ok    = START && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign hdr_n       = {hdr_hi, IN_DATA};
  assign pk_byte_vld = accept && (state == ST_LOAD);
  // WORD_CNT already counts every earlier word when the next one completes.
  assign last_word   = pk_word_done && (WORD_CNT == n_words - 16'd1);

  im_word_packer u_packer (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clr       (start_ok),
    .byte_vld  (pk_byte_vld),
    .byte_dat  (IN_DATA),
    .word_done (pk_word_done),
    .word_vld  (WE),
    .word_dat  (W_Ins)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (START) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (accept && (hdr_idx == HDR_LAST)) begin
          if (int'(hdr_n) > MAX_WORDS) state_nxt = ST_ERR;
          else if (hdr_n == 16'd0)     state_nxt = ST_AFTER_PAYLOAD;
          else                         state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (last_word) state_nxt = ST_AFTER_PAYLOAD;
      end
`ifdef IM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) state_nxt = (IN_DATA == csum) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs. A new START re-asserts CPU reset straight away.
  always_comb begin
    BUSY    = is_busy(state);
    DONE    = (state == ST_DONE);
    ERR     = (state == ST_ERR);
    CPU_RST = (state != ST_DONE) || START;
  end

  // Header capture, word address/count and stream ready.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      IN_READY <= 1'b0;
      hdr_idx  <= 1'b0;
      hdr_hi   <= '0;
      n_words  <= '0;
      WORD_CNT <= '0;
      W_Addr   <= BASE_ADDR;
    end else begin
      IN_READY <= is_busy(state_nxt);
      if (start_ok) begin
        hdr_idx  <= 1'b0;
        WORD_CNT <= '0;
      end else begin
        if (accept && (state == ST_HDR)) begin
          if (hdr_idx == HDR_LAST) begin
            n_words <= hdr_n;
            hdr_idx <= 1'b0;
          end else begin
            hdr_hi  <= IN_DATA;
            hdr_idx <= hdr_idx + 1'b1;
          end
        end
        // Address and count land together with the WE pulse.
        if (pk_word_done) begin
          W_Addr   <= BASE_ADDR + ADDR_W'({WORD_CNT, 2'b00});
          WORD_CNT <= WORD_CNT + 16'd1;
        end
      end
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)           csum <= '0;
    else if (start_ok)    csum <= '0;
    else if (pk_byte_vld) csum <= csum + IN_DATA;
  end
`endif

endmodule
